// File: rtl/ovl_code_distance_pkg.sv
// Shared types and helpers for the code-distance checker: FSM state encoding,
// fire bit positions and a constant-foldable clog2.
package ovl_code_distance_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int FIRE_RANGE  = 0;
    localparam int FIRE_XCHECK = 1;
    localparam int FIRE_COVER  = 2;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ovl_popcount.sv
// Combinational population count of an n-bit vector.
module ovl_popcount
    import ovl_code_distance_pkg::*;
#(
    parameter int n = 2
) (
    input  logic [n-1:0]              bits,
    output logic [clog2(n + 1)-1:0]   count
);

    localparam int cw = clog2(n + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < n; i++) begin
            count = count + cw'(bits[i]);
        end
    end

endmodule

// File: rtl/ovl_code_distance_ctrl.sv
// Multi-cycle Hamming distance checker: XORs two code words and counts the
// differing bits chunk by chunk, then flags distances outside [min, max].
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; X/Z operands raise fire[1] instead
// ST_SCAN  | counting chunk bits of the XOR, K enabled cycles
// ST_CHECK | publish distance, pulse done and range/coverage fires
module ovl_code_distance_ctrl
    import ovl_code_distance_pkg::*;
#(
    parameter int width          = 8,
    parameter int chunk          = 2,
    parameter int min            = 1,
    parameter int max            = 1,
    parameter int coverage_level = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          start,
    input  logic [width-1:0]              test_expr1,
    input  logic [width-1:0]              test_expr2,
    output logic                          busy,
    output logic                          done,
    output logic [clog2(width + 1)-1:0]   distance,
    output logic [2:0]                    fire
);

    localparam int dist_w   = clog2(width + 1);
    localparam int k_cycles = (width + chunk - 1) / chunk;
    localparam int cnt_w    = (clog2(k_cycles + 1) < 1) ? 1 : clog2(k_cycles + 1);
    localparam int pc_w     = clog2(chunk + 1);

    state_t             state;
    logic [width-1:0]   shift_reg;
    logic [dist_w-1:0]  acc;
    logic [cnt_w-1:0]   scan_cnt;
    logic [pc_w-1:0]    chunk_count;
    logic               operand_x;

    ovl_popcount #(.n(chunk)) u_popcount (
        .bits  (shift_reg[chunk-1:0]),
        .count (chunk_count)
    );

    // Evaluates true only in a four-state simulator; hardware sees 0.
    assign operand_x = ((^{test_expr1, test_expr2}) === 1'bx);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            acc       <= '0;
            scan_cnt  <= '0;
            distance  <= '0;
            done      <= 1'b0;
            fire      <= '0;
        end else begin
            done <= 1'b0;
            fire <= '0;
            if (enable) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (operand_x) begin
                                fire[FIRE_XCHECK] <= 1'b1;
                            end else begin
                                shift_reg <= test_expr1 ^ test_expr2;
                                acc       <= '0;
                                scan_cnt  <= cnt_w'(k_cycles - 1);
                                state     <= ST_SCAN;
                            end
                        end
                    end
                    ST_SCAN: begin
                        // Zero-fill keeps a final partial chunk from counting stale bits.
                        acc       <= acc + dist_w'(chunk_count);
                        shift_reg <= shift_reg >> chunk;
                        if (scan_cnt == '0) begin
                            state <= ST_CHECK;
                        end else begin
                            scan_cnt <= scan_cnt - 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        distance <= acc;
                        done     <= 1'b1;
                        if ((int'(acc) < min) || (int'(acc) > max)) begin
                            fire[FIRE_RANGE] <= 1'b1;
                        end
                        if ((coverage_level & 1) != 0) begin
                            fire[FIRE_COVER] <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ovl_code_distance_ctrl.sv
// Bench for ovl_code_distance_ctrl: an 8-bit and a 7-bit instance driven in
// lockstep, checked against a popcount-based reference model.
module tb_ovl_code_distance_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       start;
    logic [7:0] e1, e2;
    logic [6:0] e1_7, e2_7;

    logic       busy8, done8;
    logic [3:0] dist8;
    logic [2:0] fire8;
    logic       busy7, done7;
    logic [2:0] dist7;
    logic [2:0] fire7;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ovl_code_distance_ctrl #(
        .width(8), .chunk(2), .min(1), .max(3), .coverage_level(1)
    ) dut8 (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .test_expr1(e1), .test_expr2(e2),
        .busy(busy8), .done(done8), .distance(dist8), .fire(fire8)
    );

    ovl_code_distance_ctrl #(
        .width(7), .chunk(2), .min(1), .max(3), .coverage_level(1)
    ) dut7 (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .test_expr1(e1_7), .test_expr2(e2_7),
        .busy(busy7), .done(done7), .distance(dist7), .fire(fire7)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         gap;
        int         exp8;
        int         exp7;
        int         lat;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_fire(input int d);
        return 4 | (((d < 1) || (d > 3)) ? 1 : 0);
    endfunction

    // Launches one check; gap > 0 drops enable mid-SCAN for gap cycles while
    // start is held high to show it is ignored when busy.
    task automatic run_check(input logic [7:0] a, input logic [7:0] b, input int gap,
                             input int exp8, input int exp7, input int lat, input string tag);
        longint t0;
        int n;
        int lat8 = -1, lat7 = -1, nd8 = 0, nd7 = 0;
        int d8 = -1, d7 = -1, f8 = -1, f7 = -1;
        @(negedge clock);
        e1 = a; e2 = b; e1_7 = a[6:0]; e2_7 = b[6:0];
        start = 1'b1; enable = 1'b1;
        @(posedge clock);
        t0 = $time;
        @(negedge clock);
        start = 1'b0;
        if (gap > 0) begin
            @(negedge clock);
            enable = 1'b0; start = 1'b1;
            repeat (gap) @(negedge clock);
            enable = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            n = int'(($time - t0 - 5) / 10);
            if (done8) begin
                nd8++;
                if (lat8 < 0) begin lat8 = n; d8 = int'(dist8); f8 = int'(fire8); end
            end
            if (done7) begin
                nd7++;
                if (lat7 < 0) begin lat7 = n; d7 = int'(dist7); f7 = int'(fire7); end
            end
            @(negedge clock);
        end
        check({tag, " dist8"},  d8,   exp8);
        check({tag, " fire8"},  f8,   exp_fire(exp8));
        check({tag, " lat8"},   lat8, lat);
        check({tag, " ndone8"}, nd8,  1);
        check({tag, " dist7"},  d7,   exp7);
        check({tag, " fire7"},  f7,   exp_fire(exp7));
        check({tag, " lat7"},   lat7, lat);
        check({tag, " ndone7"}, nd7,  1);
        check({tag, " hold8"},  int'(dist8), exp8);
        check({tag, " busy8"},  int'(busy8), 0);
    endtask

    initial begin
        logic       probe;
        logic [7:0] xval;
        int         nd, nf, g;
        logic [7:0] ra, rb;

        tbl[0] = '{8'hA5, 8'hA4, 0, 1, 1, 5};
        tbl[1] = '{8'hFF, 8'h00, 0, 8, 7, 5};
        tbl[2] = '{8'h3C, 8'h3C, 0, 0, 0, 5};
        tbl[3] = '{8'h7F, 8'h00, 0, 7, 7, 5};
        tbl[4] = '{8'h0F, 8'h01, 0, 3, 3, 5};
        tbl[5] = '{8'h03, 8'h01, 2, 1, 1, 7};
        tbl[6] = '{8'hC0, 8'h00, 1, 2, 1, 6};

        reset = 1'b1; enable = 1'b0; start = 1'b0;
        e1 = '0; e2 = '0; e1_7 = '0; e2_7 = '0;
        repeat (3) @(negedge clock);
        check("rst busy",  int'(busy8), 0);
        check("rst done",  int'(done8), 0);
        check("rst dist8", int'(dist8), 0);
        check("rst fire8", int'(fire8), 0);
        check("rst dist7", int'(dist7), 0);
        reset = 1'b0;

        // start with enable low must not launch a check
        start = 1'b1; e1 = 8'hFF;
        repeat (3) @(negedge clock);
        check("idle hold busy", int'(busy8), 0);
        start = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_check(tbl[i].a, tbl[i].b, tbl[i].gap, tbl[i].exp8, tbl[i].exp7,
                      tbl[i].lat, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            g  = int'($urandom_range(2, 0));
            run_check(ra, rb, g, $countones(ra ^ rb), $countones((ra ^ rb) & 8'h7F),
                      5 + g, $sformatf("rnd%0d", i));
        end

        // reset in the second SCAN cycle aborts the check
        run_check(8'hFF, 8'h00, 0, 8, 7, 5, "pre-abort");
        @(negedge clock);
        e1 = 8'hF0; e2 = 8'h00; e1_7 = 7'h70; e2_7 = 7'h00;
        start = 1'b1; enable = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort busy",  int'(busy8), 0);
        check("abort dist8", int'(dist8), 0);
        check("abort fire8", int'(fire8), 0);
        check("abort dist7", int'(dist7), 0);
        reset = 1'b0;
        nd = 0; nf = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done8 || done7) nd++;
            if ((fire8 != 3'b000) || (fire7 != 3'b000)) nf++;
        end
        check("abort ndone", nd, 0);
        check("abort nfire", nf, 0);

        // X on an operand: only meaningful in a four-state simulator
        probe = 1'bx;
        if (probe === 1'bx) begin
            xval = 8'b1010_x010;
            @(negedge clock);
            e1 = xval; e2 = 8'h00; e1_7 = xval[6:0]; e2_7 = 7'h00;
            start = 1'b1; enable = 1'b1;
            @(negedge clock);
            start = 1'b0;
            check("x fire1", int'(fire8[1]), 1);
            check("x busy",  int'(busy8), 0);
            check("x done",  int'(done8), 0);
            @(negedge clock);
            check("x fire1 pulse", int'(fire8[1]), 0);
            check("x busy late",   int'(busy8), 0);
            e1 = 8'h00; e1_7 = 7'h00;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ovl_code_distance_ctrl.md
OVL_CODE_DISTANCE_CTRL -- requirements
Module: ovl_code_distance_ctrl

Interface
REQ-001 The block SHALL use one clock, clock; reset SHALL be synchronous and active-high, named reset.
REQ-002 Parameter width, default 8: code word width in bits, >= 1.
REQ-003 Parameter chunk, default 2: XOR bits counted per SCAN cycle, 1..width.
REQ-004 Parameter min, default 1: minimum legal Hamming distance.
REQ-005 Parameter max, default 1: maximum legal Hamming distance; min <= max <= width.
REQ-006 Parameter coverage_level, default 2: coverage enable mask; bit0 enables fire[2].
REQ-007 Port clock, input, 1: rising-edge clock.
REQ-008 Port reset, input, 1: synchronous active-high reset.
REQ-009 Port enable, input, 1: advance the FSM when high; hold all state when low.
REQ-010 Port start, input, 1: check request, sampled in IDLE only.
REQ-011 Port test_expr1, input, width: first code word.
REQ-012 Port test_expr2, input, width: second code word.
REQ-013 Port busy, output, 1: high in SCAN and CHECK.
REQ-014 Port done, output, 1: one-cycle pulse when a check completes.
REQ-015 Port distance, output, clog2(width+1): last computed Hamming distance.
REQ-016 Port fire, output, 3: bit0 = range violation, bit1 = X on operands, bit2 = check covered.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN and CHECK; the state SHALL advance only in cycles where enable = 1.
REQ-018 In IDLE, with start = 1, enable = 1 and no X/Z on the operands, the block SHALL load test_expr1 XOR test_expr2 into a shift register, clear the accumulator and enter SCAN.
REQ-019 In SCAN, each enabled cycle SHALL add popcount of the low chunk bits to the accumulator and shift the register right by chunk, zero-filling.
REQ-020 SCAN SHALL last K = ceil(width/chunk) enabled cycles, then go to CHECK.
REQ-021 In CHECK, the block SHALL update distance with the accumulator, pulse done for one cycle and return to IDLE.
REQ-022 Latency: start sampled at edge T SHALL produce done in the cycle after edge T+K+1, assuming enable stays high; each enable-low cycle adds exactly one cycle.
REQ-023 fire[0] SHALL pulse together with done when distance < min or distance > max.
REQ-024 fire[2] SHALL pulse together with done when coverage_level bit0 = 1.
REQ-025 start in SCAN or CHECK SHALL be ignored; requests are not queued.
REQ-026 X or Z on either operand while start is accepted SHALL pulse fire[1] for one cycle, with no capture and no done; the FSM SHALL stay in IDLE.
REQ-027 The accumulator SHALL be clog2(width+1) bits wide and SHALL NOT wrap; a final partial chunk counts only its valid bits.
REQ-028 distance SHALL hold its value between checks.

Reset
REQ-029 When reset = 1 at an edge, the block SHALL go to IDLE and set busy, done, distance and fire to 0, regardless of enable or start.
REQ-030 Reset during SCAN or CHECK SHALL abort the check with no done or fire pulse afterwards.

Structure
REQ-031 Package ovl_code_distance_pkg SHALL hold the state enum, the fire bit index constants (0/1/2) and the clog2 helper.
REQ-032 The design SHALL use one sub-module, ovl_popcount: a combinational popcount of a chunk-wide vector.

Verification (width=8, chunk=2, min=1, max=3, K=4)
REQ-033 8'hA5 vs 8'hA4, start at T -> done at T+5, distance = 1, fire[0] = 0, fire[2] = 1.
REQ-034 8'hFF vs 8'h00 -> distance = 8, fire[0] = 1 with done; 8'h3C vs 8'h3C -> distance = 0, fire[0] = 1.
REQ-035 enable low for 2 cycles mid-SCAN, plus start re-asserted while busy -> done at T+7; exactly one done pulse.
REQ-036 reset asserted in the 2nd SCAN cycle -> next cycle busy = 0, distance = 0, fire = 0; no done pulse follows.
REQ-037 test_expr1 = 8'b1010_x010 with start -> fire[1] = 1 for one cycle, busy stays 0, no done.
REQ-038 width=7, chunk=2, 7'h7F vs 7'h00 -> 4 SCAN cycles, distance = 7.
